// File: rtl/kmeans_centroid_update_k3_d3_if.sv
// Sample/selection stream, control strobes and new-centroid results of the
// k3/d3 centroid update block.
interface kmeans_centroid_update_k3_d3_if #(
    parameter int unsigned input_data_width = 8
);
    logic                        clear;
    logic                        valid_in;
    logic [1:0]                  selected_centroid;
    logic [input_data_width-1:0] input_data0;
    logic [input_data_width-1:0] input_data1;
    logic [input_data_width-1:0] input_data2;
    logic                        compute;
    logic                        busy;
    logic                        done;
    logic [2:0]                  empty_mask;
    logic [input_data_width-1:0] new_k0d0;
    logic [input_data_width-1:0] new_k0d1;
    logic [input_data_width-1:0] new_k0d2;
    logic [input_data_width-1:0] new_k1d0;
    logic [input_data_width-1:0] new_k1d1;
    logic [input_data_width-1:0] new_k1d2;
    logic [input_data_width-1:0] new_k2d0;
    logic [input_data_width-1:0] new_k2d1;
    logic [input_data_width-1:0] new_k2d2;

    modport master (
        output clear, valid_in, selected_centroid,
        output input_data0, input_data1, input_data2, compute,
        input  busy, done, empty_mask,
        input  new_k0d0, new_k0d1, new_k0d2,
        input  new_k1d0, new_k1d1, new_k1d2,
        input  new_k2d0, new_k2d1, new_k2d2
    );

    modport slave (
        input  clear, valid_in, selected_centroid,
        input  input_data0, input_data1, input_data2, compute,
        output busy, done, empty_mask,
        output new_k0d0, new_k0d1, new_k0d2,
        output new_k1d0, new_k1d1, new_k1d2,
        output new_k2d0, new_k2d1, new_k2d2
    );
endinterface

// File: rtl/kmeans_centroid_update_k3_d3.sv
// Accumulates per-centroid sums/counts over one pass, then derives the new
// centroids (truncated means) with a single shared restoring divider.
module kmeans_centroid_update_k3_d3 #(
    parameter int unsigned input_data_width         = 8,
    parameter int unsigned input_data_qty_bit_width = 8
) (
    input logic                             clk,
    input logic                             rst,
    kmeans_centroid_update_k3_d3_if.slave   bus
);
    localparam int unsigned W   = input_data_width;
    localparam int unsigned SW  = input_data_width + input_data_qty_bit_width + 1;
    localparam int unsigned CW  = input_data_qty_bit_width + 1;
    localparam int unsigned STW = $clog2(SW + 1);

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_DIV   = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;

    logic [SW-1:0]  sum_q  [3][3];
    logic [CW-1:0]  cnt_q  [3];
    logic [W-1:0]   data_c [3];
    logic [W-1:0]   newk_q [3][3];
    logic [2:0]     empty_q;
    logic           busy_q;
    logic           done_q;

    // Divider slot sequencing: step 0 loads, steps 1..SW shift/subtract
    logic [1:0]     k_q, d_q;
    logic [STW-1:0] step_q;
    logic [CW-1:0]  rem_q, div_q;
    logic [SW-1:0]  quo_q;

    logic [CW:0]    trial_c;
    logic           fits_c;
    logic [CW-1:0]  rem_n;
    logic [SW-1:0]  quo_n;

    logic           acc_en, clr_en, ld_en, shift_en, wr_en;

    assign data_c[0] = bus.input_data0;
    assign data_c[1] = bus.input_data1;
    assign data_c[2] = bus.input_data2;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_ACCUM;
        else      state_q <= state_d;
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d  = state_q;
        acc_en   = 1'b0;
        clr_en   = 1'b0;
        ld_en    = 1'b0;
        shift_en = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            S_ACCUM: begin
                if (bus.clear) begin
                    clr_en = 1'b1;
                end else begin
                    acc_en = bus.valid_in && (bus.selected_centroid != 2'd3);
                    if (bus.compute) state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (bus.clear) begin
                    clr_en  = 1'b1;
                    state_d = S_ACCUM;
                end else if (step_q == '0) begin
                    ld_en = 1'b1;
                end else begin
                    shift_en = 1'b1;
                    if (step_q == STW'(SW)) begin
                        wr_en = 1'b1;
                        if (k_q == 2'd2 && d_q == 2'd2) state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                clr_en  = bus.clear;
                state_d = S_ACCUM;
            end
            default: state_d = S_ACCUM;
        endcase
    end

    // Per-centroid sums and counts; wrap silently on overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
                for (int j = 0; j < 3; j++) sum_q[i][j] <= '0;
            end
        end else if (clr_en) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
                for (int j = 0; j < 3; j++) sum_q[i][j] <= '0;
            end
        end else if (acc_en) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.selected_centroid == 2'(i)) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                    for (int j = 0; j < 3; j++)
                        sum_q[i][j] <= sum_q[i][j] + SW'(data_c[j]);
                end
            end
        end
    end

    // Slot/step counters, held at zero outside DIV
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q <= '0;
            k_q    <= '0;
            d_q    <= '0;
        end else if (state_q != S_DIV || clr_en) begin
            step_q <= '0;
            k_q    <= '0;
            d_q    <= '0;
        end else if (wr_en) begin
            step_q <= '0;
            if (d_q == 2'd2) begin
                d_q <= '0;
                k_q <= k_q + 2'd1;
            end else begin
                d_q <= d_q + 2'd1;
            end
        end else begin
            step_q <= step_q + STW'(1);
        end
    end

    // One restoring step: remainder never exceeds the divisor, so CW bits hold it
    always_comb begin
        trial_c = {rem_q, quo_q[SW-1]};
        fits_c  = (trial_c >= {1'b0, div_q});
        rem_n   = fits_c ? CW'(trial_c - {1'b0, div_q}) : trial_c[CW-1:0];
        quo_n   = {quo_q[SW-2:0], fits_c};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else if (ld_en) begin
            rem_q <= '0;
            quo_q <= sum_q[k_q][d_q];
            div_q <= cnt_q[k_q];
        end else if (shift_en) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
        end
    end

    // Result registers; an empty centroid reports zero and flags itself
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            empty_q <= '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) newk_q[i][j] <= '0;
        end else if (wr_en) begin
            empty_q[k_q]     <= (div_q == '0);
            newk_q[k_q][d_q] <= (div_q == '0) ? '0 : quo_n[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d == S_DIV);
            done_q <= (state_d == S_DONE);
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.empty_mask = empty_q;
    assign bus.new_k0d0   = newk_q[0][0];
    assign bus.new_k0d1   = newk_q[0][1];
    assign bus.new_k0d2   = newk_q[0][2];
    assign bus.new_k1d0   = newk_q[1][0];
    assign bus.new_k1d1   = newk_q[1][1];
    assign bus.new_k1d2   = newk_q[1][2];
    assign bus.new_k2d0   = newk_q[2][0];
    assign bus.new_k2d1   = newk_q[2][1];
    assign bus.new_k2d2   = newk_q[2][2];

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d3.sv
// Directed bench for kmeans_centroid_update_k3_d3: hand-computed centroid
// means, divider latency, clear/abort handling and asynchronous reset.
module tb_kmeans_centroid_update_k3_d3;
    localparam int DIV_LAT = 162;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    kmeans_centroid_update_k3_d3_if #(.input_data_width(8)) bus ();

    kmeans_centroid_update_k3_d3 #(
        .input_data_width(8),
        .input_data_qty_bit_width(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] nk(input int i);
        case (i)
            0: return bus.new_k0d0;
            1: return bus.new_k0d1;
            2: return bus.new_k0d2;
            3: return bus.new_k1d0;
            4: return bus.new_k1d1;
            5: return bus.new_k1d2;
            6: return bus.new_k2d0;
            7: return bus.new_k2d1;
            default: return bus.new_k2d2;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic sample(input logic v, input logic [1:0] sel,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.valid_in          = v;
        bus.selected_centroid = sel;
        bus.input_data0       = a;
        bus.input_data1       = b;
        bus.input_data2       = c;
        tick();
        bus.valid_in = 1'b0;
    endtask

    // Pulse compute, optionally inject ignored traffic during DIV, and measure
    task automatic do_compute(input bit noise, output int lat, output int busy_cycles);
        bus.compute = 1'b1;
        tick();
        bus.compute = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!bus.done && lat < 400) begin
            if (bus.busy) busy_cycles++;
            if (noise && lat < 100) begin
                bus.valid_in          = 1'b1;
                bus.selected_centroid = 2'd1;
                bus.input_data0       = 8'd50;
                bus.input_data1       = 8'd60;
                bus.input_data2       = 8'd70;
                bus.compute           = 1'b1;
            end else begin
                bus.valid_in = 1'b0;
                bus.compute  = 1'b0;
            end
            tick();
            lat++;
        end
        bus.valid_in = 1'b0;
        bus.compute  = 1'b0;
    endtask

    task automatic load_first_scenario();
        sample(1'b1, 2'd0, 8'd10, 8'd20, 8'd30);
        sample(1'b1, 2'd0, 8'd12, 8'd22, 8'd32);
        sample(1'b1, 2'd0, 8'd14, 8'd24, 8'd34);
        sample(1'b1, 2'd0, 8'd16, 8'd26, 8'd36);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.clear = 1'b0;
        bus.valid_in = 1'b0;
        bus.selected_centroid = 2'd0;
        bus.input_data0 = '0;
        bus.input_data1 = '0;
        bus.input_data2 = '0;
        bus.compute = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
        end
        checks++;
        if (bus.empty_mask !== 3'b000) begin
            errors++;
            $display("FAIL reset_empty: got %b expected 000", bus.empty_mask);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (nk(i) !== 8'd0) begin
                errors++;
                $display("FAIL reset_newk%0d: got %0d expected 0", i, nk(i));
            end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_centroid();
        int lat, bc;
        logic [7:0] exp [9] = '{8'd13, 8'd23, 8'd33, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        pulse_clear();
        load_first_scenario();
        do_compute(1'b0, lat, bc);
        checks++;
        if (lat !== DIV_LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d expected %0d", lat, DIV_LAT);
        end
        checks++;
        if (bc !== DIV_LAT) begin
            errors++;
            $display("FAIL single_busy_cycles: got %0d expected %0d", bc, DIV_LAT);
        end
        checks++;
        if (bus.empty_mask !== 3'b110) begin
            errors++;
            $display("FAIL single_empty: got %b expected 110", bus.empty_mask);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (nk(i) !== exp[i]) begin
                errors++;
                $display("FAIL single_newk%0d: got %0d expected %0d", i, nk(i), exp[i]);
            end
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: got done=%b busy=%b expected 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_truncation();
        int lat, bc;
        logic [7:0] exp [9] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd7, 8'd0, 8'd255};
        pulse_clear();
        sample(1'b1, 2'd1, 8'd1, 8'd1, 8'd1);
        sample(1'b1, 2'd1, 8'd2, 8'd2, 8'd2);
        sample(1'b1, 2'd2, 8'd7, 8'd0, 8'd255);
        do_compute(1'b0, lat, bc);
        checks++;
        if (lat !== DIV_LAT) begin
            errors++;
            $display("FAIL trunc_latency: got %0d expected %0d", lat, DIV_LAT);
        end
        checks++;
        if (bus.empty_mask !== 3'b001) begin
            errors++;
            $display("FAIL trunc_empty: got %b expected 001", bus.empty_mask);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (nk(i) !== exp[i]) begin
                errors++;
                $display("FAIL trunc_newk%0d: got %0d expected %0d", i, nk(i), exp[i]);
            end
        end
    endtask

    task automatic test_full_pass();
        int lat, bc;
        logic [7:0] exp [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
        pulse_clear();
        for (int n = 0; n < 256; n++) sample(1'b1, 2'd2, 8'd255, 8'd255, 8'd255);
        do_compute(1'b0, lat, bc);
        checks++;
        if (bus.empty_mask !== 3'b011) begin
            errors++;
            $display("FAIL full_empty: got %b expected 011", bus.empty_mask);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (nk(i) !== exp[i]) begin
                errors++;
                $display("FAIL full_newk%0d: got %0d expected %0d", i, nk(i), exp[i]);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        int lat, bc;
        logic [7:0] exp [9] = '{8'd13, 8'd23, 8'd33, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        pulse_clear();
        sample(1'b0, 2'd1, 8'd99, 8'd99, 8'd99);
        sample(1'b1, 2'd0, 8'd10, 8'd20, 8'd30);
        sample(1'b1, 2'd3, 8'd200, 8'd200, 8'd200);
        sample(1'b1, 2'd0, 8'd12, 8'd22, 8'd32);
        sample(1'b0, 2'd2, 8'd77, 8'd77, 8'd77);
        sample(1'b1, 2'd0, 8'd14, 8'd24, 8'd34);
        sample(1'b1, 2'd3, 8'd1, 8'd2, 8'd3);
        sample(1'b1, 2'd0, 8'd16, 8'd26, 8'd36);
        do_compute(1'b1, lat, bc);
        checks++;
        if (lat !== DIV_LAT) begin
            errors++;
            $display("FAIL ignored_latency: got %0d expected %0d", lat, DIV_LAT);
        end
        checks++;
        if (bus.empty_mask !== 3'b110) begin
            errors++;
            $display("FAIL ignored_empty: got %b expected 110", bus.empty_mask);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (nk(i) !== exp[i]) begin
                errors++;
                $display("FAIL ignored_newk%0d: got %0d expected %0d", i, nk(i), exp[i]);
            end
        end
        // Sums survive DONE, so recomputing without clear repeats the result
        do_compute(1'b0, lat, bc);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (nk(i) !== exp[i]) begin
                errors++;
                $display("FAIL recompute_newk%0d: got %0d expected %0d", i, nk(i), exp[i]);
            end
        end
    endtask

    task automatic test_clear_compute();
        int lat, bc;
        int seen_done = 0;
        bus.clear = 1'b1;
        bus.compute = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.compute = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clrcmp_busy: got %b expected 0", bus.busy);
        end
        for (int n = 0; n < 5; n++) begin
            if (bus.done) seen_done++;
            tick();
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL clrcmp_done: got %0d done cycles expected 0", seen_done);
        end
        do_compute(1'b0, lat, bc);
        checks++;
        if (bus.empty_mask !== 3'b111) begin
            errors++;
            $display("FAIL clrcmp_counts_zero: got empty %b expected 111", bus.empty_mask);
        end
        checks++;
        if (nk(0) !== 8'd0) begin
            errors++;
            $display("FAIL clrcmp_newk0: got %0d expected 0", nk(0));
        end
    endtask

    task automatic test_clear_abort();
        int lat, bc;
        int seen_done = 0;
        pulse_clear();
        load_first_scenario();
        bus.compute = 1'b1;
        tick();
        bus.compute = 1'b0;
        for (int n = 0; n < 39; n++) begin
            if (bus.done) seen_done++;
            tick();
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy_done: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
        end
        for (int n = 0; n < 5; n++) begin
            if (bus.done) seen_done++;
            tick();
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done cycles expected 0", seen_done);
        end
        checks++;
        if (nk(0) !== 8'd13 || nk(1) !== 8'd23 || nk(2) !== 8'd0) begin
            errors++;
            $display("FAIL abort_partial: got %0d,%0d,%0d expected 13,23,0", nk(0), nk(1), nk(2));
        end
        checks++;
        if (bus.empty_mask !== 3'b110) begin
            errors++;
            $display("FAIL abort_empty: got %b expected 110", bus.empty_mask);
        end
        do_compute(1'b0, lat, bc);
        checks++;
        if (bus.empty_mask !== 3'b111) begin
            errors++;
            $display("FAIL abort_counts_zero: got empty %b expected 111", bus.empty_mask);
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        int zero_bad = 0;
        logic [7:0] exp [9] = '{8'd15, 8'd25, 8'd35, 8'd5, 8'd5, 8'd5, 8'd100, 8'd200, 8'd3};
        pulse_clear();
        load_first_scenario();
        do_compute(1'b0, lat, bc);
        sample(1'b1, 2'd1, 8'd4, 8'd4, 8'd4);
        bus.compute = 1'b1;
        tick();
        bus.compute = 1'b0;
        repeat (50) tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_busy: got %b expected 1", bus.busy);
        end
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) if (nk(i) !== 8'd0) zero_bad++;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.empty_mask !== 3'b000 || zero_bad !== 0) begin
            errors++;
            $display("FAIL areset_immediate: got busy=%b done=%b empty=%b nonzero_k=%0d expected 0/0/000/0",
                     bus.busy, bus.done, bus.empty_mask, zero_bad);
        end
        tick();
        #2;
        rst = 1'b1;
        tick();
        // No clear: reset alone must have zeroed the sums
        sample(1'b1, 2'd0, 8'd10, 8'd20, 8'd30);
        sample(1'b1, 2'd1, 8'd4, 8'd4, 8'd4);
        sample(1'b1, 2'd0, 8'd20, 8'd30, 8'd40);
        sample(1'b1, 2'd2, 8'd100, 8'd200, 8'd3);
        sample(1'b1, 2'd1, 8'd6, 8'd6, 8'd6);
        do_compute(1'b0, lat, bc);
        checks++;
        if (lat !== DIV_LAT) begin
            errors++;
            $display("FAIL areset_latency: got %0d expected %0d", lat, DIV_LAT);
        end
        checks++;
        if (bus.empty_mask !== 3'b000) begin
            errors++;
            $display("FAIL areset_empty: got %b expected 000", bus.empty_mask);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (nk(i) !== exp[i]) begin
                errors++;
                $display("FAIL areset_newk%0d: got %0d expected %0d", i, nk(i), exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_centroid();
        test_truncation();
        test_full_pass();
        test_ignored_inputs();
        test_clear_compute();
        test_clear_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/kmeans_centroid_update_k3_d3.md
Name: kmeans_centroid_update_k3_d3

Overview:
- Consumes the k3/d3 classification pipeline output stream: delayed sample (d0..d2) plus `selected_centroid`.
- Accumulates per-centroid per-dimension sums and sample counts over one pass of the input data.
- On request, computes the new centroids (truncated means) with a shared sequential divider.
- Feeds the top-level `new_k*` registers used for the next iteration.

Parameters:
- `input_data_width`, 8, width of each sample dimension and each centroid coordinate.
- `input_data_qty_bit_width`, 8, log2 of the maximum samples per pass (`input_data_qty` = 2**this).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  zero all sums and counts (start of pass).
- `valid_in`  in  1  sample/selection valid this cycle.
- `selected_centroid`  in  2  cluster index 0..2; value 3 is ignored.
- `input_data0`, `input_data1`, `input_data2`  in  `input_data_width` each  sample dimensions 0..2.
- `compute`  in  1  request new-centroid computation (end of pass).
- `busy`  out  1  high while dividing.
- `done`  out  1  one-cycle pulse when the `new_k*` outputs are updated.
- `empty_mask`  out  3  bit i set when centroid i received 0 samples in the last computed pass.
- `new_k0d0` … `new_k2d2`  out  `input_data_width` each  new centroid coordinates (9 ports).

Behaviour:
- Widths:
  - SW = `input_data_width` + `input_data_qty_bit_width` + 1 (sum width).
  - CW = `input_data_qty_bit_width` + 1 (count width).
  - Nine sum registers, three count registers.
- Reset (`rst`=0, asynchronous):
  - state=ACCUM; all sums and counts zero.
  - `busy`=0, `done`=0, `empty_mask`=0, all `new_k*`=0.
  - Takes effect immediately, including mid-DIV; no `done` is produced for an aborted division.
- State ACCUM:
  - `valid_in`=1 and `selected_centroid`=i (i<3): sum_i_dj += `input_data`j (zero-extended), count_i += 1, one edge.
  - `selected_centroid`=3 or `valid_in`=0: no change.
  - `clear`=1: all sums and counts go to 0 on that edge; any sample presented that cycle is discarded.
  - `compute`=1 with `clear`=0: go to DIV on the same edge; any sample presented that cycle is still accumulated first.
  - `clear` and `compute` both high: clear wins; `compute` is ignored.
- State DIV:
  - `busy`=1; `valid_in` and `compute` are ignored.
  - One restoring divider processes the 9 quotients in order k0d0,k0d1,k0d2,k1d0,…,k2d2.
  - Each slot = 1 load edge + SW shift/subtract edges = SW+1 edges. Total 9*(SW+1) edges (162 with defaults).
  - Quotient = floor(sum/count), truncated to `input_data_width`; it always fits because a mean never exceeds the max sample.
  - count_i=0: skip the division result, write `new_k`i`d*`=0 and set `empty_mask`[i]; slot timing is unchanged.
  - `new_k*` and `empty_mask` are written at the last edge of the corresponding slot and hold until the next compute or reset.
  - `clear`=1 in DIV: abort. Return to ACCUM and zero sums/counts; partially written `new_k*` values remain; no `done`.
- Sequencing: at edge E0+9*(SW+1), where E0 is the edge that samples `compute`, the state goes to DONE and `done`=1.
- State DONE: lasts one cycle, then returns to ACCUM with `done`=0.
  - Sums/counts are preserved; a new pass requires `clear`.
  - `compute` in DONE is ignored.
- More than 2**`input_data_qty_bit_width` accepted samples in one pass: sums and counts wrap modulo their widths; no flag is raised.

Test Plan:
- Reset, clear, then four samples to centroid 0: (10,20,30),(12,22,32),(14,24,34),(16,26,36). Pulse `compute` -> k0 = 13,23,33; k1 = k2 = 0; `empty_mask`=3'b110; `busy` high 162 cycles; `done` pulses once at E0+162.
- Centroid 1 gets (1,1,1),(2,2,2); centroid 2 gets (7,0,255) -> k1 = 1,1,1 (truncation); k2 = 7,0,255; `empty_mask`=3'b001.
- 256 samples of (255,255,255) to centroid 2 -> count=256 with no wrap; k2 = 255,255,255.
- Samples with `valid_in`=0, with `selected_centroid`=3, and with `valid_in`=1 during DIV -> no effect. Repeat the first scenario interleaved with these samples; results are identical.
- `clear` and `compute` high in the same cycle -> stays in ACCUM, counts zeroed, no `done`. `clear` 40 cycles into DIV -> returns to ACCUM, no `done`, `busy`=0 next cycle.
- Assert `rst`=0 asynchronously mid-DIV (between edges) -> `busy`, `done`, `empty_mask`, and all `new_k*` drop to 0 immediately; after release, a fresh pass computes correctly.
